cv32e40p_apu_arbiter: RTL and testbench

CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

---
 rtl/cv32e40p_apu_arbiter.sv | 155 +++++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one in-order APU between NUM_REQ core-side requesters.
// An ID FIFO records each issue so results are routed back to the requester that issued them.
module cv32e40p_apu_arbiter #(
    parameter int unsigned NUM_REQ          = 2,
    parameter int unsigned MAX_OUTSTANDING  = 4,
    parameter int unsigned APU_NARGS_CPU    = 3,
    parameter int unsigned APU_WOP_CPU      = 6,
    parameter int unsigned APU_NDSFLAGS_CPU = 15,
    parameter int unsigned APU_NUSFLAGS_CPU = 5
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NUM_REQ-1:0]                            req_apu_req_i,
    output logic [NUM_REQ-1:0]                            req_apu_gnt_o,
    input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]   req_operands_i,
    input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]           req_op_i,
    input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]      req_flags_i,
    output logic [NUM_REQ-1:0]                            req_rvalid_o,
    output logic [NUM_REQ-1:0][31:0]                      req_rdata_o,
    output logic [NUM_REQ-1:0][APU_NUSFLAGS_CPU-1:0]      req_rflags_o,
    output logic                                          apu_req_o,
    input  logic                                          apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                        apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                   apu_flags_o,
    input  logic                                          apu_rvalid_i,
    input  logic [31:0]                                   apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                   apu_rflags_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]          outstanding_o,
    output logic                                          full_o,
    output logic                                          error_o
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {StArb, StLock} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   winner;
    logic [IdxW-1:0]   cand_idx;
    int unsigned       cand;
    logic              found;

    logic [IdxW-1:0]   id_fifo_q [MAX_OUTSTANDING];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              error_q;

    logic              full;
    logic              handshake;
    logic              pop;
    logic [IdxW-1:0]   head;

    assign full      = (count_q == CntW'(MAX_OUTSTANDING));
    assign apu_req_o = (|req_apu_req_i) && !full;
    assign handshake = apu_req_o && apu_gnt_i;
    assign pop       = apu_rvalid_i && (count_q != '0);
    assign head      = id_fifo_q[rd_ptr_q];

    // A locked winner holds only while it keeps requesting; otherwise arbitrate afresh this cycle.
    always_comb begin
        winner   = rr_ptr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (state_q == StLock && req_apu_req_i[lock_idx_q]) begin
            winner = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = 32'(rr_ptr_q) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                cand_idx = IdxW'(cand);
                if (!found && req_apu_req_i[cand_idx]) begin
                    winner = cand_idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StArb;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = StArb;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (apu_req_o && !apu_gnt_i) begin
            state_d    = StLock;
            lock_idx_d = winner;
        end
        if (handshake) begin
            rr_ptr_d = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + IdxW'(1);
        end
    end

    always_comb begin
        req_apu_gnt_o  = '0;
        apu_operands_o = '0;
        apu_op_o       = '0;
        apu_flags_o    = '0;
        req_rvalid_o   = '0;
        req_rdata_o    = '0;
        req_rflags_o   = '0;
        if (apu_req_o) begin
            apu_operands_o = req_operands_i[winner];
            apu_op_o       = req_op_i[winner];
            apu_flags_o    = req_flags_i[winner];
        end
        if (handshake) req_apu_gnt_o[winner] = 1'b1;
        if (pop) begin
            req_rvalid_o[head] = 1'b1;
            req_rdata_o[head]  = apu_rdata_i;
            req_rflags_o[head] = apu_rflags_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && handshake) id_fifo_q[wr_ptr_q] <= winner;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (handshake) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)       rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (handshake && !pop)      count_q <= count_q + CntW'(1);
            else if (!handshake && pop) count_q <= count_q - CntW'(1);
            // A result with nothing in flight is a unit protocol violation.
            if (apu_rvalid_i && count_q == '0) error_q <= 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign full_o        = full;
    assign error_o       = error_q;

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Bench for cv32e40p_apu_arbiter: directed scenarios plus random traffic checked every cycle
// against a queue-based reference model.
module tb_cv32e40p_apu_arbiter;

    localparam int N   = 2;
    localparam int MO  = 4;
    localparam int NA  = 3;
    localparam int WOP = 6;
    localparam int NDS = 15;
    localparam int NUS = 5;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic [N-1:0]                  req_apu_req_i;
    logic [N-1:0]                  req_apu_gnt_o;
    logic [N-1:0][NA-1:0][31:0]    req_operands_i;
    logic [N-1:0][WOP-1:0]         req_op_i;
    logic [N-1:0][NDS-1:0]         req_flags_i;
    logic [N-1:0]                  req_rvalid_o;
    logic [N-1:0][31:0]            req_rdata_o;
    logic [N-1:0][NUS-1:0]         req_rflags_o;
    logic                          apu_req_o;
    logic                          apu_gnt_i;
    logic [NA-1:0][31:0]           apu_operands_o;
    logic [WOP-1:0]                apu_op_o;
    logic [NDS-1:0]                apu_flags_o;
    logic                          apu_rvalid_i;
    logic [31:0]                   apu_rdata_i;
    logic [NUS-1:0]                apu_rflags_i;
    logic [$clog2(MO+1)-1:0]       outstanding_o;
    logic                          full_o;
    logic                          error_o;

    cv32e40p_apu_arbiter #(
        .NUM_REQ(N), .MAX_OUTSTANDING(MO), .APU_NARGS_CPU(NA), .APU_WOP_CPU(WOP),
        .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_apu_req_i(req_apu_req_i), .req_apu_gnt_o(req_apu_gnt_o),
        .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_flags_i(req_flags_i),
        .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o), .req_rflags_o(req_rflags_o),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_operands_o(apu_operands_o),
        .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o), .apu_rvalid_i(apu_rvalid_i),
        .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
        .outstanding_o(outstanding_o), .full_o(full_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    bit mon = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: round-robin pointer, a pending (ungranted) winner, and a queue of issued IDs.
    int  m_rr = 0;
    bit  m_pend_v = 0;
    int  m_pend_i = 0;
    int  m_q[$];
    bit  m_err = 0;

    int                    win, h;
    bit                    found, e_req;
    logic [N-1:0]          e_gnt, e_rv;
    logic [NA-1:0][31:0]   e_ops;
    logic [WOP-1:0]        e_op;
    logic [NDS-1:0]        e_fl;
    logic [N-1:0][31:0]    e_rd;
    logic [N-1:0][NUS-1:0] e_rf;

    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            e_req = (|req_apu_req_i) && (m_q.size() < MO);
            if (m_pend_v && req_apu_req_i[m_pend_i]) begin
                win = m_pend_i;
            end else begin
                win = m_rr;
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_apu_req_i[(m_rr + k) % N]) begin
                        win = (m_rr + k) % N;
                        found = 1;
                    end
                end
            end
            e_gnt = '0;
            if (e_req && apu_gnt_i) e_gnt[win] = 1'b1;
            e_ops = e_req ? req_operands_i[win] : '0;
            e_op  = e_req ? req_op_i[win] : '0;
            e_fl  = e_req ? req_flags_i[win] : '0;
            e_rv = '0; e_rd = '0; e_rf = '0;
            if (apu_rvalid_i && m_q.size() > 0) begin
                h = m_q[0];
                e_rv[h] = 1'b1;
                e_rd[h] = apu_rdata_i;
                e_rf[h] = apu_rflags_i;
            end
            if (mon) begin
                chk("apu_req", 256'(apu_req_o), 256'(e_req));
                chk("gnt", 256'(req_apu_gnt_o), 256'(e_gnt));
                chk("operands", 256'(apu_operands_o), 256'(e_ops));
                chk("op_flags", 256'({apu_op_o, apu_flags_o}), 256'({e_op, e_fl}));
                chk("rvalid", 256'(req_rvalid_o), 256'(e_rv));
                chk("rdata", 256'(req_rdata_o), 256'(e_rd));
                chk("rflags", 256'(req_rflags_o), 256'(e_rf));
                chk("outstanding", 256'(outstanding_o), 256'(m_q.size()));
                chk("full", 256'(full_o), 256'(m_q.size() == MO));
                chk("error", 256'(error_o), 256'(m_err));
            end
            @(posedge clk_i);
            if (rst_i) begin
                m_rr = 0; m_pend_v = 0; m_pend_i = 0; m_q.delete(); m_err = 0;
            end else begin
                if (apu_rvalid_i && m_q.size() > 0) void'(m_q.pop_front());
                else if (apu_rvalid_i) m_err = 1;
                if (e_req && apu_gnt_i) begin
                    m_q.push_back(win);
                    m_rr = (win + 1) % N;
                end
                m_pend_v = e_req && !apu_gnt_i;
                m_pend_i = win;
            end
        end
    end

    logic [NA-1:0][31:0] op_a, op_b;

    task automatic idle_inputs();
        req_apu_req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
        apu_rdata_i = '0; apu_rflags_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        idle_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        op_a = {32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
        op_b = {32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
        rst_i = 1'b1;
        idle_inputs();
        req_operands_i = '0; req_op_i = '0; req_flags_i = '0;
        @(negedge clk_i);
        mon = 1;
        #3;
        chk("rst_outstanding", 256'(outstanding_o), 256'(0));
        chk("rst_full", 256'(full_o), 256'(0));
        chk("rst_error", 256'(error_o), 256'(0));
        chk("rst_rvalid", 256'(req_rvalid_o), 256'(0));
        chk("rst_apu_req", 256'(apu_req_o), 256'(0));

        // Alternating grants, latency-2 results.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            @(negedge clk_i);
            req_apu_req_i = (t < 4) ? 2'b11 : 2'b00;
            apu_gnt_i = (t < 4);
            apu_rvalid_i = (t >= 2);
            apu_rdata_i = 32'h100 + 32'(t);
            #3;
            if (t < 4) chk("alt_gnt", 256'(req_apu_gnt_o), 256'((t % 2 == 0) ? 1 : 2));
            if (t >= 2) chk("alt_rvalid", 256'(req_rvalid_o), 256'((t % 2 == 0) ? 1 : 2));
        end

        // Lock on req0 while the unit stalls; req1 follows.
        do_reset();
        req_operands_i[0] = op_a;
        req_operands_i[1] = op_b;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk_i);
            req_apu_req_i[0] = (t <= 3);
            req_apu_req_i[1] = (t >= 1 && t <= 4);
            apu_gnt_i = (t >= 3 && t <= 4);
            apu_rvalid_i = (t >= 5);
            #3;
            if (t < 3) chk("lock_ops", 256'(apu_operands_o), 256'(op_a));
            if (t < 3) chk("lock_nognt", 256'(req_apu_gnt_o), 256'(0));
            if (t == 3) chk("lock_gnt0", 256'(req_apu_gnt_o), 256'(1));
            if (t == 4) chk("lock_gnt1", 256'(req_apu_gnt_o), 256'(2));
            if (t == 4) chk("lock_ops1", 256'(apu_operands_o), 256'(op_b));
        end

        // Fill to capacity, free one slot, resume.
        do_reset();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk_i);
            req_apu_req_i = (t <= 5) ? 2'b11 : 2'b00;
            apu_gnt_i = (t <= 5);
            apu_rvalid_i = (t == 4) || (t >= 6);
            #3;
            if (t == 4) chk("full_set", 256'({full_o, apu_req_o, outstanding_o}), 256'({1'b1, 1'b0, 3'd4}));
            if (t == 5) chk("full_clr", 256'({full_o, apu_req_o, outstanding_o}), 256'({1'b0, 1'b1, 3'd3}));
        end

        // Concurrent push and pop at count 2.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            @(negedge clk_i);
            req_apu_req_i = (t <= 2) ? 2'b11 : 2'b00;
            apu_gnt_i = (t <= 2);
            apu_rvalid_i = (t >= 2);
            #3;
            if (t == 2) chk("pp_rvalid_old", 256'({req_rvalid_o, outstanding_o}), 256'({2'b01, 3'd2}));
            if (t == 3) chk("pp_count", 256'({req_rvalid_o, outstanding_o}), 256'({2'b10, 3'd2}));
        end

        // Result with nothing in flight.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            @(negedge clk_i);
            apu_rvalid_i = (t == 0);
            #3;
            if (t == 0) chk("err_norv", 256'({req_rvalid_o, error_o}), 256'(0));
            if (t == 1 || t == 4) chk("err_sticky", 256'(error_o), 256'(1));
        end
        do_reset();
        #3;
        chk("err_cleared", 256'(error_o), 256'(0));

        // Reset with IDs in flight and a lock about to form.
        do_reset();
        for (int t = 0; t < 7; t++) begin
            @(negedge clk_i);
            rst_i = (t == 3);
            req_apu_req_i = (t <= 2) ? 2'b11 : (t == 3) ? 2'b10 : (t == 4) ? 2'b11 : 2'b00;
            apu_gnt_i = (t <= 3);
            apu_rvalid_i = (t == 5);
            #3;
            if (t == 3) chk("mid_count3", 256'(outstanding_o), 256'(3));
            if (t == 4) chk("mid_count0", 256'(outstanding_o), 256'(0));
            if (t == 4) chk("mid_rr_arb", 256'(apu_operands_o), 256'(op_a));
            if (t == 5) chk("mid_drop", 256'(req_rvalid_o), 256'(0));
            if (t == 6) chk("mid_err", 256'(error_o), 256'(1));
        end

        // Random traffic.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk_i);
            rst_i = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                req_apu_req_i[i] = ($urandom_range(0, 9) < 6);
                req_op_i[i] = WOP'($urandom);
                req_flags_i[i] = NDS'($urandom);
                for (int j = 0; j < NA; j++) req_operands_i[i][j] = $urandom;
            end
            apu_gnt_i = ($urandom_range(0, 2) != 0);
            apu_rvalid_i = (m_q.size() > 0 && $urandom_range(0, 2) == 0) ||
                           ($urandom_range(0, 399) == 0);
            apu_rdata_i = $urandom;
            apu_rflags_i = NUS'($urandom);
        end
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
